// File: rtl/cursor_overlay.sv
// Final pixel-path stage: overlays a crosshair cursor on the switched VGA stream.
// Cursor position is latched once per frame; a left click flashes the cursor colour.
module cursor_overlay #(
    parameter int          SCREEN_WIDTH  = 800,
    parameter int          SCREEN_HEIGHT = 600,
    parameter int          CURSOR_ARM    = 7,
    parameter logic [11:0] CURSOR_COLOR  = 12'hFFF,
    parameter logic [11:0] CLICK_COLOR   = 12'hF00,
    parameter int          FLASH_FRAMES  = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [11:0] X_MAX      = 12'(SCREEN_WIDTH - 1);
    localparam logic [11:0] Y_MAX      = 12'(SCREEN_HEIGHT - 1);
    localparam logic [11:0] X_CENTRE   = 12'(SCREEN_WIDTH / 2);
    localparam logic [11:0] Y_CENTRE   = 12'(SCREEN_HEIGHT / 2);
    localparam logic [12:0] ARM_LEN    = 13'(CURSOR_ARM);
    localparam logic [7:0]  FRAME_LAST = 8'(FLASH_FRAMES - 1);

    typedef enum logic {IDLE, FLASH} state_t;

    function automatic logic [11:0] clamp_pos(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Magnitude of a 13-bit signed offset, returned unsigned so -4096 stays representable.
    function automatic logic [12:0] abs_off(input logic signed [12:0] d);
        return (d < 0) ? 13'(-d) : 13'(d);
    endfunction

    logic        mouse_left_d;
    logic        vsync_d;
    logic        vblnk_d;
    logic [11:0] cur_x;
    logic [11:0] cur_y;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  frame_cnt_d;
    logic [11:0] active_color;

    logic        click_rise;
    logic        vsync_rise;
    logic        vblnk_rise;

    logic signed [12:0] dx;
    logic signed [12:0] dy;
    logic               hit;

    logic [11:0] hcount_p1;
    logic [11:0] vcount_p1;
    logic        hsync_p1;
    logic        hblnk_p1;
    logic        vsync_p1;
    logic        vblnk_p1;
    logic [11:0] rgb_p1;
    logic        hit_p1;
    logic        blank_p1;
    logic [11:0] color_p1;

    assign click_rise = mouse_left & ~mouse_left_d;
    assign vsync_rise = vsync_in & ~vsync_d;
    assign vblnk_rise = vblnk_in & ~vblnk_d;

    assign dx  = $signed({1'b0, hcount_in}) - $signed({1'b0, cur_x});
    assign dy  = $signed({1'b0, vcount_in}) - $signed({1'b0, cur_y});
    assign hit = ((dy == 13'sd0) && (abs_off(dx) <= ARM_LEN)) ||
                 ((dx == 13'sd0) && (abs_off(dy) <= ARM_LEN));

    // Edge detectors and once-per-frame cursor position latch
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            mouse_left_d <= 1'b0;
            vsync_d      <= 1'b0;
            vblnk_d      <= 1'b0;
            cur_x        <= X_CENTRE;
            cur_y        <= Y_CENTRE;
        end else begin
            mouse_left_d <= mouse_left;
            vsync_d      <= vsync_in;
            vblnk_d      <= vblnk_in;
            if (vblnk_rise) begin
                cur_x <= clamp_pos(xpos, X_MAX);
                cur_y <= clamp_pos(ypos, Y_MAX);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // A fresh click always restarts the flash, even on the terminal vsync.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (click_rise) begin
                    state_d     = FLASH;
                    frame_cnt_d = 8'd0;
                end
            end
            FLASH: begin
                if (click_rise) begin
                    frame_cnt_d = 8'd0;
                end else if (vsync_rise) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d     = IDLE;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                frame_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        active_color = CURSOR_COLOR;
        if (state_q == FLASH) active_color = CLICK_COLOR;
    end

    // Stage 1: register timing, pixel, hit/blank decision and the cursor colour
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_p1 <= 12'd0;
            vcount_p1 <= 12'd0;
            hsync_p1  <= 1'b0;
            hblnk_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            vblnk_p1  <= 1'b0;
            rgb_p1    <= 12'd0;
            hit_p1    <= 1'b0;
            blank_p1  <= 1'b0;
            color_p1  <= 12'd0;
        end else begin
            hcount_p1 <= hcount_in;
            vcount_p1 <= vcount_in;
            hsync_p1  <= hsync_in;
            hblnk_p1  <= hblnk_in;
            vsync_p1  <= vsync_in;
            vblnk_p1  <= vblnk_in;
            rgb_p1    <= rgb_in;
            hit_p1    <= hit;
            blank_p1  <= hblnk_in | vblnk_in;
            color_p1  <= active_color;
        end
    end

    // Stage 2: output registers driving the VGA pins
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_out <= 12'd0;
            vcount_out <= 12'd0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_p1;
            vcount_out <= vcount_p1;
            hsync_out  <= hsync_p1;
            hblnk_out  <= hblnk_p1;
            vsync_out  <= vsync_p1;
            vblnk_out  <= vblnk_p1;
            if (blank_p1)    rgb_out <= 12'h000;
            else if (hit_p1) rgb_out <= color_p1;
            else             rgb_out <= rgb_p1;
        end
    end

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: a driver queues expected outputs, a monitor
// pops and compares them two pixel clocks later.
module tb_cursor_overlay;

    logic        pclk = 1'b0;
    logic        rst;
    logic        mouse_left;
    logic [11:0] xpos, ypos;
    logic [11:0] hcount_in, vcount_in, rgb_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;

    cursor_overlay dut (
        .pclk(pclk), .rst(rst), .mouse_left(mouse_left), .xpos(xpos), .ypos(ypos),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] h, v;
        logic        hs, hb, vs, vb;
        logic [11:0] rgb;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic step(input logic [11:0] h, input logic [11:0] v, input logic hs,
                        input logic hb, input logic vs, input logic vb,
                        input logic [11:0] rgb, input logic [11:0] exp_rgb, input string tag);
        exp_t e;
        @(posedge pclk);
        #1;
        hcount_in = h; vcount_in = v; hsync_in = hs; hblnk_in = hb;
        vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
        e.due = cyc + 2; e.h = h; e.v = v; e.hs = hs; e.hb = hb; e.vs = vs; e.vb = vb;
        e.rgb = exp_rgb; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic pix(input logic [11:0] h, input logic [11:0] v,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb, input string tag);
        step(h, v, h[3], 1'b0, 1'b0, 1'b0, rgb, exp_rgb, tag);
    endtask

    task automatic latch_pos();
        step(12'd0, 12'd620, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 12'h000, "pre_vblnk");
        step(12'd0, 12'd620, 1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 12'h000, "vblnk_rise");
        step(12'd0, 12'd621, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 12'h000, "post_vblnk");
    endtask

    task automatic vtick();
        step(12'd0, 12'd630, 1'b0, 1'b1, 1'b0, 1'b0, 12'h456, 12'h000, "pre_vsync");
        step(12'd0, 12'd630, 1'b0, 1'b1, 1'b1, 1'b0, 12'h456, 12'h000, "vsync_rise");
        step(12'd0, 12'd631, 1'b0, 1'b1, 1'b0, 1'b0, 12'h456, 12'h000, "post_vsync");
    endtask

    task automatic check_now(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", tag, act, exp_v);
        end
    endtask

    always @(negedge pclk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && sb.size() > 0) begin
            if (sb[0].due == cyc) begin
                e = sb.pop_front();
                checks += 2;
                if ({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out} !==
                    {e.h, e.v, e.hs, e.hb, e.vs, e.vb}) begin
                    errors++;
                    $display("FAIL %s timing actual=%h/%h/%b%b%b%b required=%h/%h/%b%b%b%b",
                             e.tag, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out,
                             vblnk_out, e.h, e.v, e.hs, e.hb, e.vs, e.vb);
                end
                if (rgb_out !== e.rgb) begin
                    errors++;
                    $display("FAIL %s rgb at (%0d,%0d) actual=%h required=%h",
                             e.tag, e.h, e.v, rgb_out, e.rgb);
                end
            end else if (sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s output slot missed actual=none required=cycle %0d", e.tag, e.due);
            end
        end
    end

    initial begin
        rst = 1'b0; mouse_left = 1'b0; xpos = 12'd0; ypos = 12'd0;
        hcount_in = 12'd0; vcount_in = 12'd0; rgb_in = 12'd0;
        hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
        repeat (2) @(posedge pclk);
        #2;
        check_now("reset_outputs", 64'({hcount_out, vcount_out, hsync_out, hblnk_out,
                                        vsync_out, vblnk_out, rgb_out}), 64'd0);
        rst = 1'b1;

        // Centre cursor straight out of reset
        pix(12'd400, 12'd300, 12'h5A5, 12'hFFF, "ctr");
        pix(12'd407, 12'd300, 12'h5A5, 12'hFFF, "ctr_arm_r");
        pix(12'd408, 12'd300, 12'h5A5, 12'h5A5, "ctr_past_arm");
        pix(12'd400, 12'd293, 12'h5A5, 12'hFFF, "ctr_arm_up");
        pix(12'd401, 12'd301, 12'h5A5, 12'h5A5, "ctr_diag");

        // Static cursor at (100,50)
        xpos = 12'd100; ypos = 12'd50;
        latch_pos();
        pix(12'd100, 12'd50, 12'h3C3, 12'hFFF, "s_ctr");
        pix(12'd93,  12'd50, 12'h3C3, 12'hFFF, "s_left");
        pix(12'd107, 12'd50, 12'h3C3, 12'hFFF, "s_right");
        pix(12'd100, 12'd43, 12'h3C3, 12'hFFF, "s_up");
        pix(12'd100, 12'd57, 12'h3C3, 12'hFFF, "s_down");
        pix(12'd108, 12'd50, 12'h3C3, 12'h3C3, "s_pass_r");
        pix(12'd101, 12'd51, 12'h3C3, 12'h3C3, "s_pass_diag");
        pix(12'd92,  12'd50, 12'h3C3, 12'h3C3, "s_pass_l");
        pix(12'd100, 12'd58, 12'h3C3, 12'h3C3, "s_pass_d");

        // Mid-frame move does not take effect until the next vblnk rise
        ypos = 12'd200;
        latch_pos();
        pix(12'd100, 12'd200, 12'h0F0, 12'hFFF, "m_old");
        xpos = 12'd300;
        pix(12'd100, 12'd201, 12'h0F0, 12'hFFF, "m_old_stays");
        pix(12'd300, 12'd200, 12'h0F0, 12'h0F0, "m_new_not_yet");
        pix(12'd100, 12'd207, 12'h0F0, 12'hFFF, "m_old_arm");
        latch_pos();
        pix(12'd300, 12'd200, 12'h0F0, 12'hFFF, "m_new");
        pix(12'd100, 12'd200, 12'h0F0, 12'h0F0, "m_old_gone");

        // Reset mid-line clears outputs at once and recentres the cursor
        pix(12'd50, 12'd200, 12'hABC, 12'hABC, "pre_rst_a");
        pix(12'd51, 12'd200, 12'hABC, 12'hABC, "pre_rst_b");
        @(posedge pclk);
        @(negedge pclk);
        #1;
        rst = 1'b0;
        #1;
        check_now("async_reset", 64'({hcount_out, vcount_out, hsync_out, hblnk_out,
                                      vsync_out, vblnk_out, rgb_out}), 64'd0);
        sb.delete();
        @(posedge pclk);
        @(posedge pclk);
        #2;
        rst = 1'b1;
        pix(12'd400, 12'd300, 12'hABC, 12'hFFF, "r_ctr");
        pix(12'd407, 12'd300, 12'hABC, 12'hFFF, "r_arm");
        pix(12'd300, 12'd200, 12'hABC, 12'hABC, "r_old_pos");

        // Edge clipping at the top-left corner
        xpos = 12'd3; ypos = 12'd0;
        latch_pos();
        pix(12'd0,   12'd0, 12'h111, 12'hFFF, "e_h0");
        pix(12'd3,   12'd0, 12'h111, 12'hFFF, "e_ctr");
        pix(12'd10,  12'd0, 12'h111, 12'hFFF, "e_h10");
        pix(12'd11,  12'd0, 12'h111, 12'h111, "e_h11");
        pix(12'd796, 12'd0, 12'h111, 12'h111, "e_nowrap796");
        pix(12'd799, 12'd0, 12'h111, 12'h111, "e_nowrap799");
        pix(12'd3,   12'd7, 12'h111, 12'hFFF, "e_v7");
        pix(12'd3,   12'd8, 12'h111, 12'h111, "e_v8");

        // Out-of-range position clamps to the bottom-right pixel
        xpos = 12'd1000; ypos = 12'd700;
        latch_pos();
        pix(12'd799, 12'd599, 12'h222, 12'hFFF, "c_ctr");
        pix(12'd792, 12'd599, 12'h222, 12'hFFF, "c_left");
        pix(12'd791, 12'd599, 12'h222, 12'h222, "c_past_left");
        pix(12'd799, 12'd592, 12'h222, 12'hFFF, "c_up");
        pix(12'd799, 12'd591, 12'h222, 12'h222, "c_past_up");
        pix(12'd798, 12'd598, 12'h222, 12'h222, "c_diag");

        // Blanking overrides a hit
        step(12'd799, 12'd599, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC, 12'h000, "b_hblnk");
        step(12'd799, 12'd599, 1'b0, 1'b0, 1'b0, 1'b1, 12'hABC, 12'h000, "b_vblnk");
        pix(12'd799, 12'd599, 12'hABC, 12'hFFF, "b_after");

        // Click held high: exactly 8 flash frames, no retrigger
        mouse_left = 1'b1;
        pix(12'd799, 12'd599, 12'hABC, 12'hF00, "k_start");
        for (int i = 1; i <= 8; i++) begin
            vtick();
            pix(12'd799, 12'd599, 12'hABC, (i < 8) ? 12'hF00 : 12'hFFF, "k_frame");
        end
        vtick();
        pix(12'd799, 12'd599, 12'hABC, 12'hFFF, "k_held");
        mouse_left = 1'b0;
        pix(12'd799, 12'd599, 12'hABC, 12'hFFF, "k_release");

        // Second click, then re-press after 5 frames restarts the count
        mouse_left = 1'b1;
        pix(12'd799, 12'd599, 12'hABC, 12'hF00, "k2_start");
        for (int i = 1; i <= 5; i++) begin
            vtick();
            pix(12'd799, 12'd599, 12'hABC, 12'hF00, "k2_frame");
        end
        mouse_left = 1'b0;
        pix(12'd799, 12'd599, 12'hABC, 12'hF00, "k2_release");
        mouse_left = 1'b1;
        pix(12'd799, 12'd599, 12'hABC, 12'hF00, "k2_repress");
        for (int i = 1; i <= 8; i++) begin
            vtick();
            pix(12'd799, 12'd599, 12'hABC, (i < 8) ? 12'hF00 : 12'hFFF, "k3_frame");
        end
        mouse_left = 1'b0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge pclk);
        @(negedge pclk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
